// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared defaults, width helper, FSM state and address types for the FIR TDM scheduler
package fir_pkg;

  localparam int DEF_NUM_CHN = 4;
  localparam int DEF_NUM_TAP = 3;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_CHN_W = clog2_min1(DEF_NUM_CHN);
  localparam int DEF_TAP_W = clog2_min1(DEF_NUM_TAP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_MAC
  } state_t;

  typedef struct packed {
    logic [DEF_CHN_W-1:0] chn;
    logic [DEF_TAP_W-1:0] ptr;
  } addr_t;

endpackage

// File: rtl/fir_tdm_sched_dly.sv
// rtl/fir_tdm_sched_dly.sv - fir_ctrl_dly: shift register turning the read stream into MAC load/add and result strobes
module fir_ctrl_dly #(
  parameter int CHN_W = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vld,
  input  logic             tap_first,
  input  logic             tap_last,
  input  logic [CHN_W-1:0] chn,
  output logic             acc_ld,
  output logic             acc_en,
  output logic             dout_valid,
  output logic [CHN_W-1:0] dout_chn
);

  // The result strobe trails the last product by one cycle, so vld/last/chn carry one extra stage.
  logic             vld_p   [DEPTH+1];
  logic             first_p [DEPTH];
  logic             last_p  [DEPTH+1];
  logic [CHN_W-1:0] chn_p   [DEPTH+1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= DEPTH; i++) begin
        vld_p[i]  <= 1'b0;
        last_p[i] <= 1'b0;
        chn_p[i]  <= '0;
      end
      for (int i = 0; i < DEPTH; i++) first_p[i] <= 1'b0;
    end else begin
      vld_p[0]   <= vld;
      first_p[0] <= tap_first;
      last_p[0]  <= tap_last;
      chn_p[0]   <= chn;
      for (int i = 1; i <= DEPTH; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
        chn_p[i]  <= chn_p[i-1];
      end
      for (int i = 1; i < DEPTH; i++) first_p[i] <= first_p[i-1];
    end
  end

  assign acc_ld     = vld_p[DEPTH-1] & first_p[DEPTH-1];
  assign acc_en     = vld_p[DEPTH-1] & ~first_p[DEPTH-1];
  assign dout_valid = vld_p[DEPTH] & last_p[DEPTH];
  assign dout_chn   = dout_valid ? chn_p[DEPTH] : '0;

endmodule

// File: rtl/fir_tdm_sched.sv
// rtl/fir_tdm_sched.sv - TDM scheduler sharing one sample RAM, coefficient ROM and MAC across channels
module fir_tdm_sched
  import fir_pkg::*;
#(
  parameter int NUM_CHN  = DEF_NUM_CHN,
  parameter int NUM_TAP  = DEF_NUM_TAP,
  parameter int PIPE_LAT = 2,
  localparam int CHN_W   = clog2_min1(NUM_CHN),
  localparam int TAP_W   = clog2_min1(NUM_TAP)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   din_valid_i,
  input  logic                   din_sync_i,
  output logic                   wr_en_o,
  output logic [CHN_W+TAP_W-1:0] wr_addr_o,
  output logic                   rd_en_o,
  output logic [CHN_W+TAP_W-1:0] rd_addr_o,
  output logic [TAP_W-1:0]       coef_addr_o,
  output logic                   acc_ld_o,
  output logic                   acc_en_o,
  output logic                   dout_valid_o,
  output logic [CHN_W-1:0]       dout_chn_o,
  output logic                   busy_o,
  output logic                   ovf_o,
  output logic                   sync_err_o
);

  localparam logic [CHN_W-1:0] CHN_LAST = CHN_W'(NUM_CHN - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAP - 1);

  state_t                 state, state_nx;
  logic [TAP_W-1:0]       k, k_nx;
  logic [CHN_W-1:0]       chn_r, chn_nx, chn_cnt, chn_cnt_nx, chn_inc, chn_sel;
  logic [TAP_W-1:0]       wptr [NUM_CHN];
  logic                   wptr_upd;
  logic                   wr_en_nx, rd_en_nx, first_nx, last_nx, ovf_nx, sync_err_nx;
  logic [CHN_W+TAP_W-1:0] wr_addr_nx, rd_addr_nx;
  logic [TAP_W-1:0]       coef_nx;
  logic                   rd_first, rd_last;

  // Circular buffer index (wp - kk) mod NUM_TAP; NUM_TAP need not be a power of two.
  function automatic logic [TAP_W-1:0] ptr_back(input logic [TAP_W-1:0] wp,
                                                input logic [TAP_W-1:0] kk);
    if (kk > wp) return TAP_W'(int'(wp) + NUM_TAP - int'(kk));
    return wp - kk;
  endfunction

  always_comb begin
    state_nx    = state;
    k_nx        = k;
    chn_nx      = chn_r;
    chn_cnt_nx  = chn_cnt;
    wptr_upd    = 1'b0;
    wr_en_nx    = 1'b0;
    wr_addr_nx  = '0;
    rd_en_nx    = 1'b0;
    rd_addr_nx  = '0;
    coef_nx     = '0;
    first_nx    = 1'b0;
    last_nx     = 1'b0;
    ovf_nx      = 1'b0;
    sync_err_nx = 1'b0;
    chn_inc     = (chn_cnt == CHN_LAST) ? '0 : chn_cnt + 1'b1;
    chn_sel     = din_sync_i ? '0 : chn_inc;
    unique case (state)
      ST_IDLE: begin
        if (din_valid_i) begin
          state_nx    = ST_WRITE;
          chn_nx      = chn_sel;
          chn_cnt_nx  = chn_sel;
          sync_err_nx = din_sync_i && (chn_inc != '0);
          wr_en_nx    = 1'b1;
          wr_addr_nx  = {chn_sel, wptr[chn_sel]};
        end
      end
      ST_WRITE: begin
        state_nx   = ST_MAC;
        k_nx       = '0;
        rd_en_nx   = 1'b1;
        rd_addr_nx = {chn_r, wptr[chn_r]};
        first_nx   = 1'b1;
      end
      ST_MAC: begin
        if (k == TAP_LAST) begin
          state_nx = ST_IDLE;
          wptr_upd = 1'b1;
        end else begin
          k_nx       = k + 1'b1;
          rd_en_nx   = 1'b1;
          rd_addr_nx = {chn_r, ptr_back(wptr[chn_r], k + 1'b1)};
          coef_nx    = k + 1'b1;
          last_nx    = (k + 1'b1 == TAP_LAST);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (din_valid_i && state != ST_IDLE) ovf_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      k           <= '0;
      chn_r       <= '0;
      chn_cnt     <= CHN_LAST;
      for (int c = 0; c < NUM_CHN; c++) wptr[c] <= '0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      rd_en_o     <= 1'b0;
      rd_addr_o   <= '0;
      coef_addr_o <= '0;
      rd_first    <= 1'b0;
      rd_last     <= 1'b0;
      ovf_o       <= 1'b0;
      sync_err_o  <= 1'b0;
    end else begin
      state       <= state_nx;
      k           <= k_nx;
      chn_r       <= chn_nx;
      chn_cnt     <= chn_cnt_nx;
      if (wptr_upd) wptr[chn_r] <= (wptr[chn_r] == TAP_LAST) ? '0 : wptr[chn_r] + 1'b1;
      wr_en_o     <= wr_en_nx;
      wr_addr_o   <= wr_addr_nx;
      rd_en_o     <= rd_en_nx;
      rd_addr_o   <= rd_addr_nx;
      coef_addr_o <= coef_nx;
      rd_first    <= first_nx;
      rd_last     <= last_nx;
      ovf_o       <= ovf_nx;
      sync_err_o  <= sync_err_nx;
    end
  end

  assign busy_o = (state != ST_IDLE);

  fir_ctrl_dly #(
    .CHN_W (CHN_W),
    .DEPTH (PIPE_LAT)
  ) u_dly (
    .clk        (clk),
    .rstn       (rstn),
    .vld        (rd_en_o),
    .tap_first  (rd_first),
    .tap_last   (rd_last),
    .chn        (chn_r),
    .acc_ld     (acc_ld_o),
    .acc_en     (acc_en_o),
    .dout_valid (dout_valid_o),
    .dout_chn   (dout_chn_o)
  );

endmodule
